// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flop between bit slices.
// A start/busy/done handshake frames each operation. The difference and the
// final borrow are held after done until the next operation is accepted.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;
  logic             d_bit;
  logic             br_next;

  // Full-subtractor cell acting on the current LSB slice and the borrow flop.
  always_comb begin
    d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_r   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      borrow_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          diff_r <= {d_bit, diff_r[WIDTH-1:1]};
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            borrow_r <= br_next;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign difference = diff_r;
  assign borrow     = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance driven with directed vectors
// and a 2-bit instance swept over every operand combination. Expected results
// are queued when stimulus is issued and popped by monitors at each done.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       bin2 = 1'b0;
  logic       busy2;
  logic       done2;
  logic [1:0] diff2;
  logic       borrow2;

  int compared = 0;
  int mismatched = 0;

  logic [8:0] q8[$];
  logic [2:0] q2[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .difference(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .difference(diff2), .borrow(borrow2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: every done must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8 unexpected done", 32'(done8), 32'(0));
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("w8 difference", 32'(diff8), 32'(e[8:1]));
        check("w8 borrow", 32'(borrow8), 32'(e[0]));
      end
    end
  end

  // Monitor for the 2-bit instance.
  always @(negedge clk) begin
    if (rst_n && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        check("w2 unexpected done", 32'(done2), 32'(0));
      end else begin
        logic [2:0] e;
        e = q2.pop_front();
        check("w2 difference", 32'(diff2), 32'(e[2:1]));
        check("w2 borrow", 32'(borrow2), 32'(e[0]));
      end
    end
  end

  // Issue one 8-bit op; returns at the negedge where done is seen (or timeout).
  // lat counts edges from the accept edge to done; bcnt counts busy cycles.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                     input logic [7:0] ed, input logic eb, input bit timing);
    int lat;
    int bcnt;
    @(negedge clk);
    a8 = ai; b8 = bi; bin8 = bini; start8 = 1'b1;
    q8.push_back({ed, eb});
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (timing) begin
      check("w8 done latency", 32'(lat), 32'(8));
      check("w8 busy cycles", 32'(bcnt), 32'(8));
      check("w8 busy low at done", 32'(busy8), 32'(0));
      @(negedge clk);
      check("w8 done one cycle", 32'(done8), 32'(0));
    end else begin
      check("w8 done seen", 32'(done8), 32'(1));
    end
  endtask

  task automatic wait_done8(input string nm);
    int t;
    t = 0;
    while (done8 !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(nm, 32'(done8), 32'(1));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy8), 32'(0));
    check("reset done", 32'(done8), 32'(0));
    check("reset difference", 32'(diff8), 32'(0));
    check("reset borrow", 32'(borrow8), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic subtraction vectors
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1);
    op8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b1);

    // Result holds in IDLE after done
    repeat (3) @(negedge clk);
    check("hold difference", 32'(diff8), 32'(8'hFE));
    check("hold borrow", 32'(borrow8), 32'(0));

    // Back-to-back: start held high through done
    @(negedge clk);
    a8 = 8'hA0; b8 = 8'h0A; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({8'h96, 1'b0});
    q8.push_back({8'hF0, 1'b1});
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20;
    wait_done8("b2b first done");
    @(negedge clk);
    start8 = 1'b0;
    check("b2b no idle busy", 32'(busy8), 32'(1));
    check("b2b done dropped", 32'(done8), 32'(0));
    wait_done8("b2b second done");
    @(negedge clk);

    // start while busy is ignored
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({8'h02, 1'b0});
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("ignored-start done");
    repeat (12) @(negedge clk);
    check("ignored-start queue drained", 32'(q8.size()), 32'(0));

    // Asynchronous reset during RUN
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({8'h02, 1'b0});
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy8), 32'(0));
    check("async rst done", 32'(done8), 32'(0));
    check("async rst difference", 32'(diff8), 32'(0));
    check("async rst borrow", 32'(borrow8), 32'(0));
    q8.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1);

    // Exhaustive 2-bit sweep against an arithmetic model
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int t;
          logic [1:0] ed;
          logic eb;
          ed = 2'((ia - ib - ic) & 3);
          eb = (ia < ib + ic);
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); bin2 = ic[0]; start2 = 1'b1;
          q2.push_back({ed, eb});
          @(negedge clk);
          start2 = 1'b0;
          t = 0;
          while (done2 !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
          end
          if (done2 !== 1'b1) check("w2 done timeout", 32'(done2), 32'(1));
        end
      end
    end

    repeat (4) @(negedge clk);
    check("w8 queue empty", 32'(q8.size()), 32'(0));
    check("w2 queue empty", 32'(q2.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial A - B - Bin engine built around one full-subtractor cell.
- Operands are loaded in parallel and processed LSB-first, one bit per clock.
- A borrow flop carries the borrow between bit slices.
- Produces a WIDTH-bit difference plus final borrow, with a start/busy/done handshake for use by upstream control logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; sampled on the rising edge.
- a  input  WIDTH  minuend; captured on the start-accept edge only.
- b  input  WIDTH  subtrahend; captured on the start-accept edge only.
- bin  input  1  initial borrow-in; captured on the start-accept edge only.
- busy  output  1  high while bit slices are being processed.
- done  output  1  one-cycle pulse; result is valid.
- difference  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, difference=0, borrow=0.
  - Operand shift registers, borrow flop and bit counter are cleared.
  - Reset takes effect immediately, including mid-operation.
  - The aborted operation produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: capture a, b and bin; clear the bit counter; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1.
  - Each edge processes bit 0 of the operand shift registers:
    - d = a0 ^ b0 ^ br.
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d is shifted into the MSB of the difference register, which shifts right.
  - Both operand registers shift right by one.
  - The bit counter increments.
  - On the edge that processes bit WIDTH-1: go to DONE; borrow = br_next.
- DONE:
  - done=1, busy=0, for exactly one cycle.
  - If start=1 at this edge: accept a new operation and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency:
  - start accepted at edge E0; RUN occupies the cycles after edges E0..E(WIDTH-1).
  - done is high in the cycle after edge E(WIDTH).
  - busy is high for exactly WIDTH cycles.
- Result holding:
  - difference and borrow hold their final values after done until the next start is accepted.
  - They are not cleared on return to IDLE.
  - During RUN, difference shows partial values; consumers use it only when done=1.
- start while busy=1 is ignored: operands are not re-captured and the counter is unaffected.
- Changes on a, b and bin outside the accept edge have no effect.
- Bit counter width is clog2(WIDTH)+1.
- All arithmetic is unsigned modulo 2^WIDTH; there is no signed overflow flag.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, one-cycle start → busy high 8 cycles; done pulses once, exactly 9 cycles after start; difference=0x02, borrow=0.
- a=0x03, b=0x05, bin=0 → difference=0xFE, borrow=1. Then a=0x00, b=0x00, bin=1 → difference=0xFF, borrow=1. Then a=0xFF, b=0x00, bin=1 → difference=0xFE, borrow=0.
- Back-to-back: start held high through done, with 0xA0-0x0A then 0x10-0x20 → first done gives 0x96, borrow=0; second op starts with no IDLE cycle; second done gives 0xF0, borrow=1.
- Start ignored while busy: pulse start with a=0xFF, b=0x00 at cycle 3 of a 0x05-0x03 op → result stays 0x02, borrow=0; exactly one done pulse.
- Reset mid-op: assert rst_n low at cycle 4 of RUN, asynchronously between edges → busy, done, difference and borrow go to 0 immediately; no done after release; a fresh op afterwards completes correctly.
- Exhaustive check with WIDTH=2: all 4×4×2 combinations of a, b and bin → difference equals (a-b-bin) mod 4 and borrow equals (a < b+bin), checked against a reference model at each done pulse.
